grid_cell_renderer: RTL and testbench
=====================================

// Module: grid_cell_renderer
// PURPOSE
//   Parametrised ROWS x COLS grid renderer for the 96x64 OLED pixel path. Per pixel (x,y)
//   it returns the colour of the cell under it from a 2-bit-per-cell state vector.
//   Adds pending-cell blink, a movable cursor border with wrap-around, and a registered output.
//   Sits between the game/selection logic (grid_data, move pulses) and the OLED driver.
// PARAMETERS
//   ROWS          3        grid rows (1..8)
//   COLS          3        grid columns (1..8)
//   CELL_W        30       cell width, pixels
//   CELL_H        19       cell height, pixels
//   PITCH_X       33       x distance between cell left edges (>= CELL_W)
//   PITCH_Y       22       y distance between cell top edges (>= CELL_H)
//   ORIGIN_X      0        x of cell (0,0) left edge
//   ORIGIN_Y      0        y of cell (0,0) top edge
//   CURSOR_THICK  1        cursor border thickness, pixels (>=1, < CELL_W/2 and < CELL_H/2)
//   BLINK_PERIOD  3125000  clk cycles per blink half-period (>=2)
// PORTS
//   clk           in   1            system clock
//   rst_n         in   1            synchronous reset, active-low
//   x             in   7            pixel column, 0..95
//   y             in   6            pixel row, 0..63
//   grid_data     in   2*ROWS*COLS  cell states; cell idx = r*COLS+c at bits [2*idx+1:2*idx]
//   color_sel     in   16           RGB565 for state 11 (selected)
//   color_pend    in   16           RGB565 for state 10 (pending, blinks)
//   color_lock    in   16           RGB565 for state 01 (locked)
//   color_bg      in   16           RGB565 for state 00, gaps and off-grid pixels
//   color_cursor  in   16           RGB565 for cursor border
//   move_up       in   1            one-cycle pulse: cursor row-1
//   move_down     in   1            one-cycle pulse: cursor row+1
//   move_left     in   1            one-cycle pulse: cursor col-1
//   move_right    in   1            one-cycle pulse: cursor col+1
//   cursor_row    out  $clog2(ROWS) (min 1)  current cursor row
//   cursor_col    out  $clog2(COLS) (min 1)  current cursor column
//   oled_data     out  16           registered pixel colour
// BEHAVIOUR
//   Reset (rst_n=0 at posedge clk): oled_data=0x0000, cursor_row=0, cursor_col=0,
//     blink counter=0, blink_phase=1 (pending visible). Moves ignored while in reset.
//   Hit test (comb., integer width >= 10 bits): dx=x-ORIGIN_X, dy=y-ORIGIN_Y; c=dx/PITCH_X,
//     r=dy/PITCH_Y; inside iff x>=ORIGIN_X, y>=ORIGIN_Y, c<COLS, r<ROWS, dx%PITCH_X<CELL_W,
//     dy%PITCH_Y<CELL_H. Division by constants only; a per-cell compare loop is equivalent.
//   Colour priority: off-grid/gap -> color_bg; cursor cell and pixel within CURSOR_THICK of any
//     cell edge -> color_cursor; else by state: 11 sel, 01 lock, 10 pend if blink_phase=1
//     else color_bg, 00 color_bg.
//   Latency: oled_data at posedge N reflects x, y, grid_data, colours, cursor, blink_phase
//     sampled at posedge N (1 cycle after inputs change).
//   Blink: counter 0..BLINK_PERIOD-1; on reaching BLINK_PERIOD-1 wraps to 0 and blink_phase
//     toggles. Free-running, independent of pixel scan.
//   Cursor moves: evaluated each cycle, at most one applied; priority up > down > left > right.
//     Wrap: row 0 up -> ROWS-1; row ROWS-1 down -> 0; same for columns. A move held high
//     steps every cycle (caller supplies single-cycle pulses). New cursor visible in oled_data
//     one cycle after it updates (2 cycles after the pulse).
//   Mid-operation reset: all state returns to reset values on that edge; no partial frame state.
//   Out-of-range x>95 or y>63: treated normally by hit test (normally off-grid -> color_bg).
// TESTING
//   Reset, x=0,y=0 held -> oled_data=0x0000 in reset; 1 cycle after release = color_cursor.
//   Defaults, grid_data cell4=11, x=40,y=30, cursor moved away -> color_sel next cycle;
//     x=31,y=30 (gap) -> color_bg.
//   BLINK_PERIOD=4, cell0=10, x=10,y=10, cursor at (2,2) -> color_pend 4 cycles, color_bg 4, repeat.
//   Cursor (0,0): move_up -> (2,0); move_left -> (2,2); move_up+move_left same cycle -> (1,2) only.
//   Cursor (1,1), cell4=11: x=33,y=22 -> color_cursor; x=34,y=23 -> color_sel (THICK=1).
//   ROWS=4,COLS=5,CELL_W=16,CELL_H=12,PITCH_X=19,PITCH_Y=16: cell19=01, x=80,y=50 -> color_lock;
//     x=95,y=63 -> color_bg; 15 move_right from (0,0) -> cursor_col=0.

Source files
------------

// File: rtl/grid_cell_renderer.sv
// Grid cell renderer for the 96x64 OLED pixel path.
// For each pixel (x,y) it picks the colour of the grid cell under it from a
// 2-bit-per-cell state vector. It adds a blinking "pending" state, a movable
// cursor border that wraps at the grid edges, and a registered pixel output.
module grid_cell_renderer #(
  parameter int ROWS         = 3,
  parameter int COLS         = 3,
  parameter int CELL_W       = 30,
  parameter int CELL_H       = 19,
  parameter int PITCH_X      = 33,
  parameter int PITCH_Y      = 22,
  parameter int ORIGIN_X     = 0,
  parameter int ORIGIN_Y     = 0,
  parameter int CURSOR_THICK = 1,
  parameter int BLINK_PERIOD = 3125000,
  localparam int ROW_W       = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int COL_W       = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [6:0]               x,
  input  logic [5:0]               y,
  input  logic [2*ROWS*COLS-1:0]   grid_data,
  input  logic [15:0]              color_sel,
  input  logic [15:0]              color_pend,
  input  logic [15:0]              color_lock,
  input  logic [15:0]              color_bg,
  input  logic [15:0]              color_cursor,
  input  logic                     move_up,
  input  logic                     move_down,
  input  logic                     move_left,
  input  logic                     move_right,
  output logic [ROW_W-1:0]         cursor_row,
  output logic [COL_W-1:0]         cursor_col,
  output logic [15:0]              oled_data
);

  localparam int BLINK_W = $clog2(BLINK_PERIOD);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_PERIOD - 1);
  localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(COLS - 1);

  // Hit-test intermediates; int keeps all arithmetic well above 10 bits.
  int dx;
  int dy;
  int hit_col;
  int hit_row;
  int off_x;
  int off_y;
  int cell_idx;

  logic        in_cell;
  logic        on_border;
  logic        is_cursor_cell;
  logic [1:0]  cell_state;
  logic [15:0] pixel_color;

  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;

  logic [ROW_W-1:0] row_next;
  logic [COL_W-1:0] col_next;

  // Locate the cell under the pixel and the pixel offset inside its pitch box.
  always_comb begin
    dx       = int'(x) - ORIGIN_X;
    dy       = int'(y) - ORIGIN_Y;
    hit_col  = dx / PITCH_X;
    hit_row  = dy / PITCH_Y;
    off_x    = dx % PITCH_X;
    off_y    = dy % PITCH_Y;
    cell_idx = hit_row * COLS + hit_col;
    in_cell  = (dx >= 0) && (dy >= 0) &&
               (hit_col < COLS) && (hit_row < ROWS) &&
               (off_x < CELL_W) && (off_y < CELL_H);
    on_border = (off_x < CURSOR_THICK) || (off_x >= CELL_W - CURSOR_THICK) ||
                (off_y < CURSOR_THICK) || (off_y >= CELL_H - CURSOR_THICK);
    is_cursor_cell = (hit_row == int'(cursor_row)) && (hit_col == int'(cursor_col));
  end

  // Pick the 2-bit state of the hit cell; a compare loop avoids indexing past the vector.
  always_comb begin
    cell_state = 2'b00;
    for (int i = 0; i < ROWS * COLS; i++) begin
      if (i == cell_idx) begin
        cell_state = grid_data[2*i +: 2];
      end
    end
  end

  // Colour priority: background for gaps/off-grid, then cursor border, then cell state.
  always_comb begin
    pixel_color = color_bg;
    if (in_cell) begin
      if (is_cursor_cell && on_border) begin
        pixel_color = color_cursor;
      end else begin
        unique case (cell_state)
          2'b11:   pixel_color = color_sel;
          2'b01:   pixel_color = color_lock;
          2'b10:   pixel_color = blink_phase ? color_pend : color_bg;
          default: pixel_color = color_bg;
        endcase
      end
    end
  end

  // Register the pixel colour so the OLED driver sees a clean one-cycle-latency stream.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      oled_data <= 16'h0000;
    end else begin
      oled_data <= pixel_color;
    end
  end

  // Free-running blink timer; the phase flips each time the counter wraps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + BLINK_W'(1);
    end
  end

  // Apply at most one move per cycle (up > down > left > right), wrapping at the grid edges.
  always_comb begin
    row_next = cursor_row;
    col_next = cursor_col;
    if (move_up) begin
      row_next = (cursor_row == '0) ? ROW_LAST : cursor_row - ROW_W'(1);
    end else if (move_down) begin
      row_next = (cursor_row == ROW_LAST) ? '0 : cursor_row + ROW_W'(1);
    end else if (move_left) begin
      col_next = (cursor_col == '0) ? COL_LAST : cursor_col - COL_W'(1);
    end else if (move_right) begin
      col_next = (cursor_col == COL_LAST) ? '0 : cursor_col + COL_W'(1);
    end
  end

  // Cursor position register; moves are ignored while reset is asserted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cursor_row <= '0;
      cursor_col <= '0;
    end else begin
      cursor_row <= row_next;
      cursor_col <= col_next;
    end
  end

endmodule

// File: tb/tb_grid_cell_renderer.sv
// Directed testbench for grid_cell_renderer: a default 3x3 grid (fast blink)
// and a 4x5 grid sharing clock, reset, pixel position and colours.
module tb_grid_cell_renderer;

  localparam logic [15:0] C_SEL  = 16'hF800;
  localparam logic [15:0] C_PEND = 16'h07E0;
  localparam logic [15:0] C_LOCK = 16'h001F;
  localparam logic [15:0] C_BG   = 16'h1234;
  localparam logic [15:0] C_CUR  = 16'hFFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  x;
  logic [5:0]  y;
  logic [17:0] grid_a;
  logic [39:0] grid_b;
  logic        up_a, down_a, left_a, right_a;
  logic        up_b, down_b, left_b, right_b;
  logic [1:0]  row_a;
  logic [1:0]  col_a;
  logic [15:0] oled_a;
  logic [1:0]  row_b;
  logic [2:0]  col_b;
  logic [15:0] oled_b;

  int checks = 0;
  int errors = 0;
  int cyc;

  always #5 clk = ~clk;

  // Cycles since reset release; edge k after release has cyc == k.
  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  grid_cell_renderer #(.BLINK_PERIOD(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .grid_data(grid_a),
    .color_sel(C_SEL), .color_pend(C_PEND), .color_lock(C_LOCK),
    .color_bg(C_BG), .color_cursor(C_CUR),
    .move_up(up_a), .move_down(down_a), .move_left(left_a), .move_right(right_a),
    .cursor_row(row_a), .cursor_col(col_a), .oled_data(oled_a)
  );

  grid_cell_renderer #(.ROWS(4), .COLS(5), .CELL_W(16), .CELL_H(12),
                       .PITCH_X(19), .PITCH_Y(16), .BLINK_PERIOD(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .grid_data(grid_b),
    .color_sel(C_SEL), .color_pend(C_PEND), .color_lock(C_LOCK),
    .color_bg(C_BG), .color_cursor(C_CUR),
    .move_up(up_b), .move_down(down_b), .move_left(left_b), .move_right(right_b),
    .cursor_row(row_b), .cursor_col(col_b), .oled_data(oled_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_a(input logic u, input logic d, input logic l, input logic r);
    up_a = u; down_a = d; left_a = l; right_a = r;
    tick();
    up_a = 0; down_a = 0; left_a = 0; right_a = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; x = 0; y = 0; grid_a = '0; grid_b = '0;
    up_a = 1; down_a = 0; left_a = 0; right_a = 0;
    up_b = 0; down_b = 0; left_b = 0; right_b = 1;
    repeat (3) tick();
    checks++;
    if (oled_a !== 16'h0000) begin
      errors++; $display("[TB] FAIL reset_oled_a: got %h expected %h", oled_a, 16'h0000);
    end
    checks++;
    if (oled_b !== 16'h0000) begin
      errors++; $display("[TB] FAIL reset_oled_b: got %h expected %h", oled_b, 16'h0000);
    end
    checks++;
    if ({row_a, col_a} !== 4'b0000) begin
      errors++; $display("[TB] FAIL reset_cursor_a: got %h expected %h", {row_a, col_a}, 4'b0000);
    end
    checks++;
    if ({row_b, col_b} !== 5'b00000) begin
      errors++; $display("[TB] FAIL reset_cursor_b: got %h expected %h", {row_b, col_b}, 5'b00000);
    end
    up_a = 0; right_b = 0; rst_n = 1;
    tick();
    checks++;
    if (oled_a !== C_CUR) begin
      errors++; $display("[TB] FAIL release_oled_a: got %h expected %h", oled_a, C_CUR);
    end
    checks++;
    if (oled_b !== C_CUR) begin
      errors++; $display("[TB] FAIL release_oled_b: got %h expected %h", oled_b, C_CUR);
    end
  endtask

  task automatic test_cursor_moves();
    logic [3:0] exp_pos [6];
    logic [3:0] moves   [6];
    exp_pos = '{4'b10_00, 4'b10_10, 4'b01_10, 4'b01_00, 4'b10_00, 4'b00_00};
    // move bits: {up, down, left, right}
    moves   = '{4'b1000, 4'b0010, 4'b1010, 4'b0001, 4'b0100, 4'b0100};
    for (int i = 0; i < 6; i++) begin
      pulse_a(moves[i][3], moves[i][2], moves[i][1], moves[i][0]);
      checks++;
      if ({row_a, col_a} !== exp_pos[i]) begin
        errors++;
        $display("[TB] FAIL move_step%0d: got row %0d col %0d expected row %0d col %0d",
                 i, row_a, col_a, exp_pos[i][3:2], exp_pos[i][1:0]);
      end
    end
  endtask

  task automatic test_cell_colors();
    int          xs  [10];
    int          ys  [10];
    logic [15:0] exp [10];
    grid_a = '0;
    grid_a[1:0]   = 2'b01;
    grid_a[5:4]   = 2'b01;
    grid_a[9:8]   = 2'b11;
    grid_a[17:16] = 2'b11;
    xs  = '{40, 31, 70, 95, 95, 29, 28, 120, 99, 45};
    ys  = '{30, 30,  5, 60, 63, 10, 10,  10,  5, 20};
    exp = '{C_SEL, C_BG, C_LOCK, C_SEL, C_BG, C_CUR, C_LOCK, C_BG, C_BG, C_BG};
    for (int i = 0; i < 10; i++) begin
      x = 7'(xs[i]); y = 6'(ys[i]);
      tick();
      checks++;
      if (oled_a !== exp[i]) begin
        errors++;
        $display("[TB] FAIL color_x%0d_y%0d: got %h expected %h", xs[i], ys[i], oled_a, exp[i]);
      end
    end
  endtask

  task automatic test_cursor_border();
    int          xs  [7];
    int          ys  [7];
    logic [15:0] exp [7];
    pulse_a(0, 1, 0, 0);
    pulse_a(0, 0, 0, 1);
    checks++;
    if ({row_a, col_a} !== 4'b01_01) begin
      errors++; $display("[TB] FAIL border_cursor_pos: got row %0d col %0d expected row 1 col 1", row_a, col_a);
    end
    xs  = '{33, 34, 62, 61, 40, 40, 0};
    ys  = '{22, 23, 30, 30, 40, 39, 0};
    exp = '{C_CUR, C_SEL, C_CUR, C_SEL, C_CUR, C_SEL, C_LOCK};
    for (int i = 0; i < 7; i++) begin
      x = 7'(xs[i]); y = 6'(ys[i]);
      tick();
      checks++;
      if (oled_a !== exp[i]) begin
        errors++;
        $display("[TB] FAIL border_x%0d_y%0d: got %h expected %h", xs[i], ys[i], oled_a, exp[i]);
      end
    end
  endtask

  task automatic test_blink();
    logic [15:0] exp;
    pulse_a(0, 1, 0, 0);
    pulse_a(0, 0, 0, 1);
    checks++;
    if ({row_a, col_a} !== 4'b10_10) begin
      errors++; $display("[TB] FAIL blink_cursor_pos: got row %0d col %0d expected row 2 col 2", row_a, col_a);
    end
    grid_a = '0;
    grid_a[1:0] = 2'b10;
    x = 10; y = 10;
    for (int i = 0; i < 16; i++) begin
      tick();
      exp = ((((cyc - 1) / 4) % 2) == 0) ? C_PEND : C_BG;
      checks++;
      if (oled_a !== exp) begin
        errors++; $display("[TB] FAIL blink_cycle%0d: got %h expected %h", cyc, oled_a, exp);
      end
    end
  endtask

  task automatic test_mid_reset();
    up_a = 1; rst_n = 0;
    tick();
    checks++;
    if ({row_a, col_a} !== 4'b0000) begin
      errors++; $display("[TB] FAIL midreset_cursor: got row %0d col %0d expected row 0 col 0", row_a, col_a);
    end
    checks++;
    if (oled_a !== 16'h0000) begin
      errors++; $display("[TB] FAIL midreset_oled: got %h expected %h", oled_a, 16'h0000);
    end
    up_a = 0; rst_n = 1;
    tick();
    checks++;
    if (oled_a !== C_PEND) begin
      errors++; $display("[TB] FAIL midreset_blink_on: got %h expected %h", oled_a, C_PEND);
    end
    repeat (4) tick();
    checks++;
    if (oled_a !== C_BG) begin
      errors++; $display("[TB] FAIL midreset_blink_off: got %h expected %h", oled_a, C_BG);
    end
  endtask

  task automatic test_big_grid();
    int          xs  [4];
    int          ys  [4];
    logic [15:0] exp [4];
    grid_b = '0;
    grid_b[39:38] = 2'b01;
    xs  = '{80, 95, 0, 18};
    ys  = '{50, 63, 0, 5};
    exp = '{C_LOCK, C_BG, C_CUR, C_BG};
    for (int i = 0; i < 4; i++) begin
      x = 7'(xs[i]); y = 6'(ys[i]);
      tick();
      checks++;
      if (oled_b !== exp[i]) begin
        errors++;
        $display("[TB] FAIL big_x%0d_y%0d: got %h expected %h", xs[i], ys[i], oled_b, exp[i]);
      end
    end
    right_b = 1;
    repeat (7) tick();
    checks++;
    if ({row_b, col_b} !== 5'b00_010) begin
      errors++; $display("[TB] FAIL big_right7: got row %0d col %0d expected row 0 col 2", row_b, col_b);
    end
    repeat (8) tick();
    right_b = 0;
    checks++;
    if ({row_b, col_b} !== 5'b00_000) begin
      errors++; $display("[TB] FAIL big_right15: got row %0d col %0d expected row 0 col 0", row_b, col_b);
    end
  endtask

  initial begin
    test_reset();
    test_cursor_moves();
    test_cell_colors();
    test_cursor_border();
    test_blink();
    test_mid_reset();
    test_big_grid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
